ctrl_frame_tx_engine: RTL and testbench



---
 rtl/ctrl_frame_pkg.sv | 25 ++
 rtl/ctrl_frame_tx_engine_if.sv | 12 +
 rtl/ctrl_frame_ram.sv | 27 ++
 rtl/ctrl_frame_tx_engine.sv | 195 +++++++++++++++++++
 tb/tb_ctrl_frame_tx_engine.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_frame_pkg.sv
// Shared definitions for the control-frame transmit engine: FSM encoding,
// CTRL bit positions, register offsets and the default minimum frame length.
package ctrl_frame_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_TX   = 2'd2,
      S_END  = 2'd3
   } state_t;

   localparam int CTRL_TX      = 31;
   localparam int CTRL_READY   = 30;
   localparam int CTRL_BUSY    = 29;
   localparam int CTRL_ABORT   = 28;
   localparam int CTRL_DONE    = 27;
   localparam int CTRL_IRQ_EN  = 26;
   localparam int CTRL_LEN_ERR = 25;

   localparam logic [23:0] OFF_CTRL = 24'h00_0000;
   localparam logic [23:0] OFF_STAT = 24'h00_0004;

   localparam int MIN_LEN_DEFAULT = 60;

endpackage

// File: rtl/ctrl_frame_tx_engine_if.sv
// picosoc iomem bus bundle; the CPU side is the master, the engine the slave.
interface ctrl_frame_tx_engine_if;
   logic        valid;
   logic        ready;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output valid, wstrb, addr, wdata, input ready, rdata);
   modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/ctrl_frame_ram.sv
// Frame buffer: byte-lane write port shared with a CPU read, plus an
// independent read port for the transmitter. Both reads are combinational.
module ctrl_frame_ram #(
   parameter int WORDS = 64,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr_a,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata_a,
   input  logic [AW-1:0] addr_b,
   output logic [31:0]   rdata_b
);

   logic [31:0] mem [WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr_a][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata_a = mem[addr_a];
   assign rdata_b = mem[addr_b];

endmodule

// File: rtl/ctrl_frame_tx_engine.sv
// Control-frame transmitter: CPU fills a frame buffer over iomem, then the
// engine streams a padded frame into a subset of PHY-TX FIFOs under mutex.
module ctrl_frame_tx_engine
   import ctrl_frame_pkg::*;
#(
   parameter int         NUM_PORTS = 4,
   parameter int         RAM_WORDS = 64,
   parameter int         MIN_LEN   = MIN_LEN_DEFAULT,
   parameter logic [7:0] CFG_BASE  = 8'h15,
   parameter logic [7:0] RAM_BASE  = 8'h05
) (
   input  logic                 clk,
   input  logic                 arst,
   ctrl_frame_tx_engine_if.slave iomem,
   output logic [7:0]           o_fifo_din,
   output logic                 o_fifo_del,
   input  logic [NUM_PORTS-1:0] fifo_afull,
   output logic [NUM_PORTS-1:0] fifo_wren,
   output logic [NUM_PORTS-1:0] mutex_req,
   input  logic [NUM_PORTS-1:0] mutex_val,
   output logic                 irq
);

   localparam int AW        = $clog2(RAM_WORDS);
   localparam int LW        = 13;
   localparam int MAX_BYTES = RAM_WORDS * 4;

   state_t               state;
   logic [NUM_PORTS-1:0] mask_reg, tx_mask, new_mask;
   logic [11:0]          len_reg, tx_len, new_len;
   logic [LW-1:0]        eff_len, cnt, start_eff;
   logic                 done, irq_en, len_err, aborting, abort_pend;
   logic [15:0]          sent_cnt, abort_cnt;
   logic [31:0]          ctrl_rdata, ram_rdata_a, ram_rdata_b;
   logic [7:0]           mask8, tx_byte;
   logic [3:0]           ram_we;
   logic                 req, cfg_hit, ram_hit, ctrl_wr, tx_wr, abort_wr, stall;
   logic                 unused_bits;

   assign req      = iomem.valid && !iomem.ready;
   assign cfg_hit  = (iomem.addr[31:24] == CFG_BASE) &&
                     (iomem.addr[23:0] == OFF_CTRL || iomem.addr[23:0] == OFF_STAT);
   assign ram_hit  = (iomem.addr[31:24] == RAM_BASE) &&
                     ((iomem.addr[23:0] >> (AW + 2)) == 24'd0);
   assign ctrl_wr  = req && cfg_hit && (iomem.addr[23:0] == OFF_CTRL) && (|iomem.wstrb);
   assign tx_wr    = ctrl_wr && iomem.wstrb[3] && iomem.wdata[CTRL_TX];
   assign abort_wr = ctrl_wr && iomem.wstrb[3] && iomem.wdata[CTRL_ABORT];
   assign stall    = |(fifo_afull & tx_mask);
   assign ram_we   = (req && ram_hit && state == S_IDLE) ? iomem.wstrb : 4'b0000;
   assign irq      = done & irq_en;
   assign unused_bits = ^{iomem.wdata[30:29], iomem.wdata[24:12]};

   ctrl_frame_ram #(.WORDS(RAM_WORDS), .AW(AW)) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .addr_a  (iomem.addr[AW+1:2]),
      .wdata   (iomem.wdata),
      .rdata_a (ram_rdata_a),
      .addr_b  (cnt[AW+1:2]),
      .rdata_b (ram_rdata_b)
   );

   // Post-write view of len/mask, so a single CTRL write can program and launch.
   always_comb begin
      new_len  = len_reg;
      new_mask = mask_reg;
      if (ctrl_wr && iomem.wstrb[0]) new_len[7:0]  = iomem.wdata[7:0];
      if (ctrl_wr && iomem.wstrb[1]) new_len[11:8] = iomem.wdata[11:8];
      if (ctrl_wr && iomem.wstrb[2]) new_mask      = iomem.wdata[16 +: NUM_PORTS];
      start_eff = LW'(new_len);
      if (start_eff > LW'(MAX_BYTES)) start_eff = LW'(MAX_BYTES);
      if (start_eff < LW'(MIN_LEN))   start_eff = LW'(MIN_LEN);
   end

   always_comb begin
      mask8                  = '0;
      mask8[NUM_PORTS-1:0]   = mask_reg;
      ctrl_rdata             = '0;
      ctrl_rdata[CTRL_READY]   = (state == S_IDLE);
      ctrl_rdata[CTRL_BUSY]    = (state != S_IDLE);
      ctrl_rdata[CTRL_DONE]    = done;
      ctrl_rdata[CTRL_IRQ_EN]  = irq_en;
      ctrl_rdata[CTRL_LEN_ERR] = len_err;
      ctrl_rdata[23:16]      = mask8;
      ctrl_rdata[11:0]       = len_reg;
      tx_byte                = 8'h00;
      if (cnt < LW'(tx_len)) tx_byte = ram_rdata_b[{cnt[1:0], 3'b000} +: 8];
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         iomem.ready <= 1'b0;
         iomem.rdata <= '0;
      end else begin
         iomem.ready <= req && (cfg_hit || ram_hit);
         iomem.rdata <= '0;
         if (req && cfg_hit)
            iomem.rdata <= (iomem.addr[23:0] == OFF_STAT) ? {abort_cnt, sent_cnt} : ctrl_rdata;
         else if (req && ram_hit)
            iomem.rdata <= ram_rdata_a;
      end
   end

   // Sticky set events are written after the W1C handling so a set wins a same-cycle clear.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state      <= S_IDLE;
         mask_reg   <= '0;
         tx_mask    <= '0;
         len_reg    <= '0;
         tx_len     <= '0;
         eff_len    <= '0;
         cnt        <= '0;
         done       <= 1'b0;
         irq_en     <= 1'b0;
         len_err    <= 1'b0;
         aborting   <= 1'b0;
         abort_pend <= 1'b0;
         sent_cnt   <= '0;
         abort_cnt  <= '0;
         o_fifo_din <= '0;
         o_fifo_del <= 1'b0;
         fifo_wren  <= '0;
         mutex_req  <= '0;
      end else begin
         fifo_wren  <= '0;
         o_fifo_del <= 1'b0;
         if (ctrl_wr) begin
            len_reg  <= new_len;
            mask_reg <= new_mask;
            if (iomem.wstrb[3]) begin
               irq_en <= iomem.wdata[CTRL_IRQ_EN];
               if (iomem.wdata[CTRL_DONE])    done    <= 1'b0;
               if (iomem.wdata[CTRL_LEN_ERR]) len_err <= 1'b0;
            end
         end
         case (state)
            S_IDLE: begin
               if (tx_wr) begin
                  if (new_len == 12'd0 || new_mask == '0) begin
                     len_err <= 1'b1;
                  end else begin
                     tx_mask    <= new_mask;
                     tx_len     <= new_len;
                     eff_len    <= start_eff;
                     cnt        <= '0;
                     aborting   <= 1'b0;
                     abort_pend <= 1'b0;
                     mutex_req  <= new_mask;
                     state      <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (abort_wr) begin
                  mutex_req <= '0;
                  abort_cnt <= abort_cnt + 16'd1;
                  state     <= S_IDLE;
               end else if ((mutex_val & tx_mask) == tx_mask) begin
                  state <= S_TX;
               end
            end
            S_TX: begin
               if (abort_wr) abort_pend <= 1'b1;
               if (!stall) begin
                  fifo_wren <= tx_mask;
                  if (abort_pend || abort_wr) begin
                     o_fifo_din <= 8'h00;
                     o_fifo_del <= 1'b1;
                     aborting   <= 1'b1;
                     state      <= S_END;
                  end else begin
                     o_fifo_din <= tx_byte;
                     o_fifo_del <= (cnt == eff_len - 1'b1);
                     cnt        <= cnt + 1'b1;
                     if (cnt == eff_len - 1'b1) state <= S_END;
                  end
               end
            end
            S_END: begin
               mutex_req <= '0;
               if (aborting) begin
                  abort_cnt <= abort_cnt + 16'd1;
               end else begin
                  done     <= 1'b1;
                  sent_cnt <= sent_cnt + 16'd1;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_frame_tx_engine.sv
// Directed bench for ctrl_frame_tx_engine: CPU bus tasks, a FIFO-side monitor
// and one task per scenario with hand-computed expectations.
module tb_ctrl_frame_tx_engine;

   localparam int NP = 4;
   localparam logic [31:0] CFG  = 32'h1500_0000;
   localparam logic [31:0] STAT = 32'h1500_0004;
   localparam logic [31:0] RAM  = 32'h0500_0000;

   logic          clk = 1'b0;
   logic          arst = 1'b1;
   logic [NP-1:0] fifo_afull, fifo_wren, mutex_req, mutex_val;
   logic [7:0]    o_fifo_din;
   logic          o_fifo_del, irq;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]    byte_q [$];
   logic          del_q  [$];
   logic [NP-1:0] wren_q [$];
   int            cyc_q  [$];
   logic [7:0]    shadow [256];

   ctrl_frame_tx_engine_if bus ();

   ctrl_frame_tx_engine #(
      .NUM_PORTS (NP),
      .RAM_WORDS (64),
      .MIN_LEN   (60),
      .CFG_BASE  (8'h15),
      .RAM_BASE  (8'h05)
   ) dut (
      .clk        (clk),
      .arst       (arst),
      .iomem      (bus),
      .o_fifo_din (o_fifo_din),
      .o_fifo_del (o_fifo_del),
      .fifo_afull (fifo_afull),
      .fifo_wren  (fifo_wren),
      .mutex_req  (mutex_req),
      .mutex_val  (mutex_val),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO-side monitor: record every written byte, sampled mid-cycle.
   always @(negedge clk) begin
      if (|fifo_wren) begin
         byte_q.push_back(o_fifo_din);
         del_q.push_back(o_fifo_del);
         wren_q.push_back(fifo_wren);
         cyc_q.push_back(cyc);
      end
   end

   function automatic logic [7:0] exp_byte(int k, int len);
      return (k < len) ? shadow[k] : 8'h00;
   endfunction

   task automatic clear_q();
      byte_q.delete();
      del_q.delete();
      wren_q.delete();
      cyc_q.delete();
   endtask

   task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [31:0] rd, output logic acked);
      @(negedge clk);
      bus.valid = 1'b1;
      bus.addr  = addr;
      bus.wdata = data;
      bus.wstrb = strb;
      acked = 1'b0;
      rd    = '0;
      for (int i = 0; i < 8 && !acked; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            acked = 1'b1;
            rd    = bus.rdata;
         end
      end
      bus.valid = 1'b0;
      bus.wstrb = 4'b0000;
   endtask

   task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] rd;
      logic        ack;
      bus_xfer(addr, data, strb, rd, ack);
      total++;
      if (ack !== 1'b1) begin
         bad++;
         $display("[TB] FAIL write_ack addr=%h: got ready=%b, required 1", addr, ack);
      end
   endtask

   task automatic cpu_read(input logic [31:0] addr, output logic [31:0] rd);
      logic ack;
      bus_xfer(addr, 32'h0, 4'b0000, rd, ack);
      total++;
      if (ack !== 1'b1) begin
         bad++;
         $display("[TB] FAIL read_ack addr=%h: got ready=%b, required 1", addr, ack);
      end
   endtask

   task automatic write_word(input int i, input logic [31:0] data);
      cpu_write(RAM + 32'(4 * i), data, 4'hF);
      for (int b = 0; b < 4; b++) shadow[4*i+b] = data[8*b +: 8];
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (mutex_req !== '0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (mutex_req !== '0) begin
         bad++;
         $display("[TB] FAIL frame_timeout: mutex_req=%b after %0d cycles, required 0", mutex_req, n);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        ack;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.ready, bus.rdata, o_fifo_din, o_fifo_del, fifo_wren, mutex_req, irq} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: ready=%b rdata=%h din=%h del=%b wren=%b req=%b irq=%b, required all 0",
                  bus.ready, bus.rdata, o_fifo_din, o_fifo_del, fifo_wren, mutex_req, irq);
      end
      arst = 1'b0;
      cpu_read(CFG, rd);
      total++;
      if (rd !== 32'h4000_0000) begin bad++; $display("[TB] FAIL reset_ctrl: got %h, required 40000000", rd); end
      cpu_read(STAT, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_stat: got %h, required 00000000", rd); end
      bus_xfer(32'h2000_0000, 32'h0, 4'b0000, rd, ack);
      total++;
      if (ack !== 1'b0) begin bad++; $display("[TB] FAIL unmapped_ack: got %b, required 0", ack); end
      bus_xfer(CFG + 32'h8, 32'h0, 4'b0000, rd, ack);
      total++;
      if (ack !== 1'b0) begin bad++; $display("[TB] FAIL cfg_hole_ack: got %b, required 0", ack); end
      cpu_write(CFG, 32'h00FF_0010, 4'b0100);
      cpu_read(CFG, rd);
      total++;
      if (rd !== 32'h400F_0000) begin bad++; $display("[TB] FAIL mask_lane: got %h, required 400F0000", rd); end
   endtask

   task automatic test_basic_frame();
      logic [31:0] rd;
      mutex_val  = '1;
      fifo_afull = '0;
      clear_q();
      for (int i = 0; i < 16; i++) write_word(i, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
      cpu_read(RAM + 32'd12, rd);
      total++;
      if (rd !== 32'h0F0E_0D0C) begin bad++; $display("[TB] FAIL ram_readback: got %h, required 0F0E0D0C", rd); end
      cpu_write(CFG, 32'h8005_0040, 4'hF);
      wait_idle();
      total++;
      if (byte_q.size() != 64) begin bad++; $display("[TB] FAIL basic_count: got %0d, required 64", byte_q.size()); end
      for (int k = 0; k < byte_q.size(); k++) begin
         total++;
         if (byte_q[k] !== exp_byte(k, 64) || del_q[k] !== (k == 63) || wren_q[k] !== 4'b0101) begin
            bad++;
            $display("[TB] FAIL basic_byte%0d: got %h/del%b/wren%b, required %h/del%b/wren0101",
                     k, byte_q[k], del_q[k], wren_q[k], exp_byte(k, 64), (k == 63));
         end
      end
      cpu_read(STAT, rd);
      total++;
      if (rd !== 32'h0000_0001) begin bad++; $display("[TB] FAIL basic_stat: got %h, required 00000001", rd); end
      cpu_read(CFG, rd);
      total++;
      if (rd !== 32'h4805_0040) begin bad++; $display("[TB] FAIL basic_ctrl: got %h, required 48050040", rd); end
   endtask

   task automatic test_padding();
      clear_q();
      for (int i = 0; i < 5; i++) write_word(i, {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)});
      cpu_write(CFG, 32'h8001_0014, 4'hF);
      wait_idle();
      total++;
      if (byte_q.size() != 60) begin bad++; $display("[TB] FAIL pad_count: got %0d, required 60", byte_q.size()); end
      for (int k = 0; k < byte_q.size(); k++) begin
         total++;
         if (byte_q[k] !== ((k < 20) ? 8'(k + 1) : 8'h00) || del_q[k] !== (k == 59) || wren_q[k] !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL pad_byte%0d: got %h/del%b/wren%b, required %h/del%b/wren0001",
                     k, byte_q[k], del_q[k], wren_q[k], ((k < 20) ? 8'(k + 1) : 8'h00), (k == 59));
         end
      end
   endtask

   task automatic test_afull();
      clear_q();
      cpu_write(CFG, 32'h8004_0040, 4'hF);
      for (int i = 0; i < 500 && byte_q.size() < 10; i++) @(negedge clk);
      fifo_afull[2] = 1'b1;
      repeat (5) @(negedge clk);
      fifo_afull = '0;
      wait_idle();
      total++;
      if (byte_q.size() != 64) begin bad++; $display("[TB] FAIL afull_count: got %0d, required 64", byte_q.size()); end
      for (int k = 0; k < byte_q.size(); k++) begin
         total++;
         if (byte_q[k] !== exp_byte(k, 64) || del_q[k] !== (k == 63) || wren_q[k] !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL afull_byte%0d: got %h/del%b/wren%b, required %h/del%b/wren0100",
                     k, byte_q[k], del_q[k], wren_q[k], exp_byte(k, 64), (k == 63));
         end
      end
      if (byte_q.size() == 64) begin
         total++;
         if (cyc_q[63] - cyc_q[0] + 1 != 69) begin
            bad++;
            $display("[TB] FAIL afull_span: got %0d cycles, required 69", cyc_q[63] - cyc_q[0] + 1);
         end
      end
   endtask

   task automatic test_len_clamp();
      logic [31:0] rd;
      clear_q();
      for (int i = 0; i < 64; i++)
         write_word(i, {8'(4*i+3) ^ 8'h5A, 8'(4*i+2) ^ 8'h5A, 8'(4*i+1) ^ 8'h5A, 8'(4*i) ^ 8'h5A});
      cpu_write(CFG, 32'h8001_012C, 4'hF);
      wait_idle();
      total++;
      if (byte_q.size() != 256) begin bad++; $display("[TB] FAIL clamp_count: got %0d, required 256", byte_q.size()); end
      for (int k = 0; k < byte_q.size(); k++) begin
         total++;
         if (byte_q[k] !== exp_byte(k, 300) || del_q[k] !== (k == 255)) begin
            bad++;
            $display("[TB] FAIL clamp_byte%0d: got %h/del%b, required %h/del%b",
                     k, byte_q[k], del_q[k], exp_byte(k, 300), (k == 255));
         end
      end
      cpu_read(STAT, rd);
      total++;
      if (rd !== 32'h0000_0004) begin bad++; $display("[TB] FAIL clamp_stat: got %h, required 00000004", rd); end
   endtask

   task automatic test_abort_wait();
      logic [31:0] rd;
      clear_q();
      mutex_val = '0;
      cpu_write(CFG, 32'h0800_0000, 4'b1000);
      cpu_write(CFG, 32'h8003_0040, 4'hF);
      repeat (4) @(negedge clk);
      total++;
      if (mutex_req !== 4'b0011) begin bad++; $display("[TB] FAIL wait_req: got %b, required 0011", mutex_req); end
      cpu_write(RAM, 32'hDEAD_BEEF, 4'hF);
      cpu_read(RAM, rd);
      total++;
      if (rd !== {shadow[3], shadow[2], shadow[1], shadow[0]}) begin
         bad++;
         $display("[TB] FAIL busy_write_drop: got %h, required %h", rd, {shadow[3], shadow[2], shadow[1], shadow[0]});
      end
      cpu_read(CFG, rd);
      total++;
      if (rd !== 32'h2003_0040) begin bad++; $display("[TB] FAIL wait_ctrl: got %h, required 20030040", rd); end
      cpu_write(CFG, 32'h1000_0000, 4'b1000);
      repeat (3) @(negedge clk);
      total++;
      if (mutex_req !== '0 || byte_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL wait_abort: got req=%b writes=%0d, required req=0000 writes=0", mutex_req, byte_q.size());
      end
      cpu_read(STAT, rd);
      total++;
      if (rd !== 32'h0001_0004) begin bad++; $display("[TB] FAIL wait_abort_stat: got %h, required 00010004", rd); end
      cpu_read(CFG, rd);
      total++;
      if (rd !== 32'h4003_0040) begin bad++; $display("[TB] FAIL wait_abort_ctrl: got %h, required 40030040", rd); end
      mutex_val = '1;
   endtask

   task automatic test_abort_tx();
      logic [31:0] rd;
      clear_q();
      fifo_afull = '1;
      cpu_write(CFG, 32'h8002_0040, 4'hF);
      repeat (4) @(negedge clk);
      fifo_afull = '0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      fifo_afull = '1;
      cpu_write(CFG, 32'h1000_0000, 4'b1000);
      repeat (2) @(negedge clk);
      fifo_afull = '0;
      wait_idle();
      total++;
      if (byte_q.size() != 11) begin bad++; $display("[TB] FAIL abort_count: got %0d, required 11", byte_q.size()); end
      for (int k = 0; k < byte_q.size() && k < 11; k++) begin
         total++;
         if (byte_q[k] !== ((k < 10) ? shadow[k] : 8'h00) || del_q[k] !== (k == 10)) begin
            bad++;
            $display("[TB] FAIL abort_byte%0d: got %h/del%b, required %h/del%b",
                     k, byte_q[k], del_q[k], ((k < 10) ? shadow[k] : 8'h00), (k == 10));
         end
      end
      cpu_read(STAT, rd);
      total++;
      if (rd !== 32'h0002_0004) begin bad++; $display("[TB] FAIL abort_stat: got %h, required 00020004", rd); end
      cpu_read(CFG, rd);
      total++;
      if (rd !== 32'h4002_0040 || irq !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_ctrl: got %h irq=%b, required 40020040 irq=0", rd, irq);
      end
   endtask

   task automatic test_len_err_irq();
      logic [31:0] rd;
      cpu_write(CFG, 32'h8005_0000, 4'hF);
      repeat (3) @(negedge clk);
      total++;
      if (mutex_req !== '0) begin bad++; $display("[TB] FAIL len0_req: got %b, required 0000", mutex_req); end
      cpu_read(CFG, rd);
      total++;
      if (rd !== 32'h4205_0000) begin bad++; $display("[TB] FAIL len0_ctrl: got %h, required 42050000", rd); end
      cpu_write(CFG, 32'h8200_0014, 4'hF);
      cpu_read(CFG, rd);
      total++;
      if (rd !== 32'h4200_0014) begin bad++; $display("[TB] FAIL mask0_ctrl: got %h, required 42000014", rd); end
      clear_q();
      cpu_write(CFG, 32'h8605_0040, 4'hF);
      total++;
      if (irq !== 1'b0 || mutex_req !== 4'b0101) begin
         bad++;
         $display("[TB] FAIL irq_busy: got irq=%b req=%b, required irq=0 req=0101", irq, mutex_req);
      end
      wait_idle();
      total++;
      if (irq !== 1'b1 || byte_q.size() != 64) begin
         bad++;
         $display("[TB] FAIL irq_done: got irq=%b writes=%0d, required irq=1 writes=64", irq, byte_q.size());
      end
      cpu_read(CFG, rd);
      total++;
      if (rd !== 32'h4C05_0040) begin bad++; $display("[TB] FAIL irq_ctrl: got %h, required 4C050040", rd); end
      cpu_read(STAT, rd);
      total++;
      if (rd !== 32'h0002_0005) begin bad++; $display("[TB] FAIL final_stat: got %h, required 00020005", rd); end
      cpu_write(CFG, 32'h0C00_0000, 4'b1000);
      @(negedge clk);
      total++;
      if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_clear: got %b, required 0", irq); end
   endtask

   initial begin
      bus.valid  = 1'b0;
      bus.wstrb  = 4'b0000;
      bus.addr   = '0;
      bus.wdata  = '0;
      fifo_afull = '0;
      mutex_val  = '0;
      test_reset();
      test_basic_frame();
      test_padding();
      test_afull();
      test_len_clamp();
      test_abort_wait();
      test_abort_tx();
      test_len_err_irq();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
